icache_line_fill: RTL
=====================

ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

Interface
REQ-001 SHALL have parameters: PADDR_W 40 physical address width; LINE_W 512 cache line bits; BEAT_W 128 memory beat bits; INDEX_W 12 invalidation index width; N_BEATS = LINE_W/BEAT_W (4), derived.
REQ-002 SHALL have ports (name direction width meaning):
 clk_i  in  1  single clock, rising edge
 rstn_i  in  1  reset, asynchronous, active-low
 ifill_req_valid_i  in  1  icache miss fill request
 ifill_req_paddr_i  in  PADDR_W  miss physical address
 ifill_kill_i  in  1  icache abandons current fill
 ifill_resp_valid_o  out  1  full line valid, one-cycle pulse
 ifill_resp_ack_o  out  1  request accepted, one-cycle pulse
 ifill_resp_data_o  out  LINE_W  assembled line
 inv_req_valid_i  in  1  external invalidation
 inv_req_paddr_i  in  INDEX_W  index to invalidate
 inv_valid_o  out  1  invalidation to icache
 inv_paddr_o  out  INDEX_W  index to icache
 mem_req_valid_o  out  1  memory read request
 mem_req_ready_i  in  1  memory accepts request
 mem_req_addr_o  out  PADDR_W  line-aligned read address
 mem_resp_valid_i  in  1  beat valid
 mem_resp_data_i  in  BEAT_W  beat data

Function
REQ-003 SHALL implement FSM states IDLE, REQ, RESP, DONE, DRAIN.
REQ-004 IDLE: ifill_req_valid_i=1 and ifill_kill_i=0 -> latch paddr, go REQ; ifill_req_valid_i with ifill_kill_i same cycle -> not accepted, stay IDLE.
REQ-005 ifill_resp_ack_o SHALL pulse high exactly the cycle after acceptance; ifill_req_valid_i outside IDLE SHALL be ignored.
REQ-006 mem_req_addr_o SHALL equal latched paddr with low log2(LINE_W/8) bits (6) zeroed, stable while mem_req_valid_o=1.
REQ-007 REQ: mem_req_valid_o=1 held until mem_req_ready_i=1; never deasserted before handshake, even if killed.
REQ-008 Handshake cycle: go RESP if no kill pending, else DRAIN; beat counter cleared to 0.
REQ-009 RESP/DRAIN: each mem_resp_valid_i cycle consumes one beat; beat k written to data buffer bits [k*BEAT_W +: BEAT_W] (RESP only); counter increments, wraps to 0 after N_BEATS-1.
REQ-010 RESP last beat (counter=N_BEATS-1) -> DONE; DRAIN last beat -> IDLE, no response.
REQ-011 DONE: ifill_resp_valid_o=1 for exactly one cycle, then IDLE; same-cycle new request not accepted (accepted from IDLE next cycle earliest).
REQ-012 ifill_kill_i in REQ SHALL set kill-pending flag; in RESP SHALL go DRAIN next cycle (beat arriving same cycle counted, not written); in DONE or IDLE SHALL have no effect.
REQ-013 ifill_resp_data_o SHALL be registered, stable from DONE until next beat write; only changes on RESP beat writes.
REQ-014 Minimum latency acceptance->resp_valid: 1 (REQ) + N_BEATS beat cycles + 1 (DONE), with ready and beats back-to-back.
REQ-015 inv_valid_o/inv_paddr_o SHALL be inv_req_*_i registered one cycle, independent of FSM state; inv_paddr_o holds last value when inv_valid_o=0.
REQ-016 mem_resp_valid_i in IDLE, REQ or DONE SHALL be ignored.

Reset
REQ-017 rstn_i=0 SHALL asynchronously force state IDLE, counter 0, kill flag 0, data buffer 0, all outputs 0.
REQ-018 Reset mid-fill SHALL abandon the fill; beats after reset release are ignored in IDLE.

Verification
REQ-019 Req paddr 0x80001234, ready immediate, beats 0xA..,0xB..,0xC..,0xD.. back-to-back -> ack cycle+1, mem_req_addr_o 0x80001200, resp_valid 1 cycle at cycle 6, data = {D,C,B,A}.
REQ-020 Ready delayed 5 cycles, beats with 2-cycle gaps -> mem_req_valid_o held steady 6 cycles, correct line, single resp pulse.
REQ-021 Kill during REQ before ready -> request completes handshake, 4 beats drained, no resp_valid, back to IDLE, data output unchanged.
REQ-022 Kill after beat 1 in RESP -> remaining beats discarded, no resp_valid; following request fills normally.
REQ-023 inv_req_valid_i=1 index 0x5A3 during active fill -> inv_valid_o=1, inv_paddr_o=0x5A3 next cycle; fill unaffected.
REQ-024 rstn_i low after beat 2 -> all outputs 0 immediately; stray beats post-reset ignored; next request completes correctly.

Source files
------------

// File: rtl/icache_line_fill.sv
// Instruction-cache line fill engine: issues one line-aligned memory read per miss,
// assembles N_BEATS beats into a line, and forwards external invalidations.
module icache_line_fill #(
  parameter int PADDR_W = 40,
  parameter int LINE_W  = 512,
  parameter int BEAT_W  = 128,
  parameter int INDEX_W = 12
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               ifill_req_valid_i,
  input  logic [PADDR_W-1:0] ifill_req_paddr_i,
  input  logic               ifill_kill_i,
  output logic               ifill_resp_valid_o,
  output logic               ifill_resp_ack_o,
  output logic [LINE_W-1:0]  ifill_resp_data_o,
  input  logic               inv_req_valid_i,
  input  logic [INDEX_W-1:0] inv_req_paddr_i,
  output logic               inv_valid_o,
  output logic [INDEX_W-1:0] inv_paddr_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [PADDR_W-1:0] mem_req_addr_o,
  input  logic               mem_resp_valid_i,
  input  logic [BEAT_W-1:0]  mem_resp_data_i
);

  localparam int N_BEATS = LINE_W / BEAT_W;
  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [PADDR_W-1:0] LINE_MASK = ~((PADDR_W'(1) << OFF_W) - PADDR_W'(1));

  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             kill_pend;
  logic             beat_last;
  logic [CNT_W-1:0] beat_nxt;

  assign beat_last = (beat_cnt == CNT_W'(N_BEATS - 1));
  assign beat_nxt  = beat_last ? '0 : beat_cnt + CNT_W'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state              <= IDLE;
      beat_cnt           <= '0;
      kill_pend          <= 1'b0;
      ifill_resp_valid_o <= 1'b0;
      ifill_resp_ack_o   <= 1'b0;
      ifill_resp_data_o  <= '0;
      inv_valid_o        <= 1'b0;
      inv_paddr_o        <= '0;
      mem_req_valid_o    <= 1'b0;
      mem_req_addr_o     <= '0;
    end else begin
      ifill_resp_ack_o   <= 1'b0;
      ifill_resp_valid_o <= 1'b0;

      // Invalidation path is a plain one-cycle register, unrelated to the fill FSM
      inv_valid_o <= inv_req_valid_i;
      if (inv_req_valid_i) inv_paddr_o <= inv_req_paddr_i;

      case (state)
        IDLE: begin
          if (ifill_req_valid_i && !ifill_kill_i) begin
            mem_req_addr_o   <= ifill_req_paddr_i & LINE_MASK;
            mem_req_valid_o  <= 1'b1;
            ifill_resp_ack_o <= 1'b1;
            kill_pend        <= 1'b0;
            state            <= REQ;
          end
        end
        // The read request cannot be withdrawn; a kill here only redirects the beats to DRAIN
        REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            beat_cnt        <= '0;
            kill_pend       <= 1'b0;
            state           <= (kill_pend || ifill_kill_i) ? DRAIN : RESP;
          end else if (ifill_kill_i) begin
            kill_pend <= 1'b1;
          end
        end
        RESP: begin
          if (mem_resp_valid_i) begin
            beat_cnt <= beat_nxt;
            if (!ifill_kill_i) begin
              for (int k = 0; k < N_BEATS; k++)
                if (beat_cnt == CNT_W'(k)) ifill_resp_data_o[k*BEAT_W +: BEAT_W] <= mem_resp_data_i;
            end
          end
          if (mem_resp_valid_i && beat_last) begin
            if (ifill_kill_i) begin
              state <= IDLE;
            end else begin
              state              <= DONE;
              ifill_resp_valid_o <= 1'b1;
            end
          end else if (ifill_kill_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_resp_valid_i) begin
            beat_cnt <= beat_nxt;
            if (beat_last) state <= IDLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
